// File: rtl/ids_input_arbiter.sv
// ids_input_arbiter: two-input packet arbiter in front of the IDS datapath.
// Each requester feeds its own fallthrough FIFO. A three-state FSM
// (IDLE/HDR/BODY) grants one FIFO at a time and holds the grant for a whole
// packet, alternating between requesters when both have data waiting.
// Optional feature: define IDS_ARB_PKT_CNT_EN to build the per-requester
// forwarded-packet counters; otherwise pkt_cnt0/pkt_cnt1 read as zero.

// Fallthrough FIFO: the head word is visible on rd_data while not empty.
module ids_input_arbiter_fifo #(
   parameter int WIDTH      = 72,
   parameter int DEPTH_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             nearly_full
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] FULL_LEVEL = (DEPTH_BITS+1)'(DEPTH);
   // One slot of slack so a writer that saw rdy=1 may still write next cycle.
   localparam logic [DEPTH_BITS:0] NF_LEVEL   = (DEPTH_BITS+1)'(DEPTH - 1);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [WIDTH-1:0]      mem_d [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_BITS:0]   count_q, count_d;
   logic                  do_wr;
   logic                  do_rd;

   // Next-state for storage, pointers and occupancy; simultaneous push/pop keeps count.
   always_comb begin
      do_wr    = wr_en && (count_q != FULL_LEVEL);
      do_rd    = rd_en && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage words carry no reset; only pointers and occupancy are cleared.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Control registers with asynchronous clear, which empties the FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data     = mem_q[rd_ptr_q];
   assign empty       = (count_q == '0);
   assign nearly_full = (count_q >= NF_LEVEL);

endmodule

module ids_input_arbiter #(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter int FIFO_DEPTH_BITS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in0_data,
   input  logic [CTRL_WIDTH-1:0] in0_ctrl,
   input  logic                  in0_wr,
   output logic                  in0_rdy,
   input  logic [DATA_WIDTH-1:0] in1_data,
   input  logic [CTRL_WIDTH-1:0] in1_ctrl,
   input  logic                  in1_wr,
   output logic                  in1_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   output logic                  grant,
   output logic                  busy,
   output logic [31:0]           pkt_cnt0,
   output logic [31:0]           pkt_cnt1
);

   localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_BODY = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;

   logic [WORD_W-1:0] f0_head, f1_head, head_sel;
   logic              f0_empty, f1_empty, head_empty;
   logic              f0_nf, f1_nf;
   logic              pop0, pop1;
   logic              ctrl_is_zero;

   ids_input_arbiter_fifo #(
      .WIDTH      (WORD_W),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
   ) u_fifo0 (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (in0_wr),
      .wr_data     ({in0_ctrl, in0_data}),
      .rd_en       (pop0),
      .rd_data     (f0_head),
      .empty       (f0_empty),
      .nearly_full (f0_nf)
   );

   ids_input_arbiter_fifo #(
      .WIDTH      (WORD_W),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
   ) u_fifo1 (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (in1_wr),
      .wr_data     ({in1_ctrl, in1_data}),
      .rd_en       (pop1),
      .rd_data     (f1_head),
      .empty       (f1_empty),
      .nearly_full (f1_nf)
   );

   assign in0_rdy = ~f0_nf;
   assign in1_rdy = ~f1_nf;

   // The granted FIFO head drives the output bus directly.
   assign head_sel     = grant_q ? f1_head  : f0_head;
   assign head_empty   = grant_q ? f1_empty : f0_empty;
   assign out_ctrl     = head_sel[WORD_W-1:DATA_WIDTH];
   assign out_data     = head_sel[DATA_WIDTH-1:0];
   assign ctrl_is_zero = (out_ctrl == '0);

   assign grant = grant_q;
   assign busy  = (state_q != ST_IDLE);
   assign pop0  = out_wr && !grant_q;
   assign pop1  = out_wr &&  grant_q;

   // Arbitration FSM: pick a requester in IDLE, then follow packet framing until the last word.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      out_wr       = (state_q != ST_IDLE) && out_rdy && !head_empty;
      case (state_q)
         ST_IDLE: begin
            if (!f0_empty && !f1_empty) begin
               grant_d = ~last_grant_q;
               state_d = ST_HDR;
            end else if (!f0_empty) begin
               grant_d = 1'b0;
               state_d = ST_HDR;
            end else if (!f1_empty) begin
               grant_d = 1'b1;
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            // Any number of module-header words precede the body.
            if (out_wr && ctrl_is_zero) begin
               state_d = ST_BODY;
            end
         end
         ST_BODY: begin
            // First non-zero ctrl after the body starts is the packet's last word.
            if (out_wr && !ctrl_is_zero) begin
               state_d      = ST_IDLE;
               last_grant_d = grant_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM registers; last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

`ifdef IDS_ARB_PKT_CNT_EN
   logic [31:0] pkt_cnt0_q, pkt_cnt0_d;
   logic [31:0] pkt_cnt1_q, pkt_cnt1_d;
   logic        pkt_done;

   // Count completed packets per requester; counters wrap naturally at 2^32.
   always_comb begin
      pkt_done   = (state_q == ST_BODY) && out_wr && !ctrl_is_zero;
      pkt_cnt0_d = pkt_cnt0_q;
      pkt_cnt1_d = pkt_cnt1_q;
      if (pkt_done && !grant_q) begin
         pkt_cnt0_d = pkt_cnt0_q + 32'd1;
      end
      if (pkt_done && grant_q) begin
         pkt_cnt1_d = pkt_cnt1_q + 32'd1;
      end
   end

   // Packet counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_cnt0_q <= '0;
         pkt_cnt1_q <= '0;
      end else begin
         pkt_cnt0_q <= pkt_cnt0_d;
         pkt_cnt1_q <= pkt_cnt1_d;
      end
   end

   assign pkt_cnt0 = pkt_cnt0_q;
   assign pkt_cnt1 = pkt_cnt1_q;
`else
   assign pkt_cnt0 = '0;
   assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_ids_input_arbiter.sv
// Directed bench for ids_input_arbiter: reset state, single packet with
// latency, tie-break order, back-to-back packets, output stall and reset
// in the middle of a packet.
module tb_ids_input_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] in0_data = '0, in1_data = '0;
   logic [7:0]  in0_ctrl = '0, in1_ctrl = '0;
   logic        in0_wr = 1'b0, in1_wr = 1'b0;
   logic        in0_rdy, in1_rdy;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic        out_wr;
   logic        out_rdy = 1'b1;
   logic        grant, busy;
   logic [31:0] pkt_cnt0, pkt_cnt1;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] cyc = '0;
   logic        stop_drv = 1'b0;
   logic [31:0] start_cyc [2];

`ifdef IDS_ARB_PKT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct packed {
      logic        g;
      logic [7:0]  c;
      logic [63:0] d;
      logic [31:0] cyc;
   } mon_t;

   mon_t mon_q[$];

   ids_input_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .in0_data (in0_data),
      .in0_ctrl (in0_ctrl),
      .in0_wr   (in0_wr),
      .in0_rdy  (in0_rdy),
      .in1_data (in1_data),
      .in1_ctrl (in1_ctrl),
      .in1_wr   (in1_wr),
      .in1_rdy  (in1_rdy),
      .out_data (out_data),
      .out_ctrl (out_ctrl),
      .out_wr   (out_wr),
      .out_rdy  (out_rdy),
      .grant    (grant),
      .busy     (busy),
      .pkt_cnt0 (pkt_cnt0),
      .pkt_cnt1 (pkt_cnt1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   always @(negedge clk) begin : mon_blk
      mon_t m;
      if (!reset && out_wr === 1'b1) begin
         m.g   = grant;
         m.c   = out_ctrl;
         m.d   = out_data;
         m.cyc = cyc;
         mon_q.push_back(m);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] exp_ctrl(int idx, int n);
      if (idx == 0)     return 8'hFF;
      if (idx == n - 1) return 8'h01;
      return 8'h00;
   endfunction

   function automatic logic [63:0] exp_data(int req, int id, int idx);
      return {16'(req), 16'(id), 32'(idx)};
   endfunction

   task automatic send_pkts(input int req, input int id0, input int npkt, input int n);
      for (int p = 0; p < npkt; p++) begin
         for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            @(posedge clk); #1;
            if (req == 0) in0_wr = 1'b0; else in1_wr = 1'b0;
            while (!(req == 0 ? in0_rdy : in1_rdy) && !stop_drv && t < 200) begin
               @(posedge clk); #1;
               t++;
            end
            if (stop_drv) return;
            if (t >= 200) begin
               n_checks++;
               $display("FAIL drv_rdy_timeout req=%0d rdy=0 required=1", req);
               return;
            end
            if (p == 0 && i == 0) start_cyc[req] = cyc;
            if (req == 0) begin
               in0_ctrl = exp_ctrl(i, n);
               in0_data = exp_data(0, id0 + p, i);
               in0_wr   = 1'b1;
            end else begin
               in1_ctrl = exp_ctrl(i, n);
               in1_data = exp_data(1, id0 + p, i);
               in1_wr   = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      if (req == 0) in0_wr = 1'b0; else in1_wr = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in0_wr   = 1'b0;
      in1_wr   = 1'b0;
      out_rdy  = 1'b1;
      stop_drv = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      mon_q.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
      n_checks++; if (out_wr !== 1'b0) $display("FAIL rst_out_wr got=%b exp=0", out_wr); else n_pass++;
      n_checks++; if (grant !== 1'b0) $display("FAIL rst_grant got=%b exp=0", grant); else n_pass++;
      n_checks++; if (in0_rdy !== 1'b1) $display("FAIL rst_in0_rdy got=%b exp=1", in0_rdy); else n_pass++;
      n_checks++; if (in1_rdy !== 1'b1) $display("FAIL rst_in1_rdy got=%b exp=1", in1_rdy); else n_pass++;
      n_checks++; if (pkt_cnt0 !== 32'd0) $display("FAIL rst_pkt_cnt0 got=%0d exp=0", pkt_cnt0); else n_pass++;
      n_checks++; if (pkt_cnt1 !== 32'd0) $display("FAIL rst_pkt_cnt1 got=%0d exp=0", pkt_cnt1); else n_pass++;
   endtask

   task automatic test_single_packet();
      logic [31:0] exp_cnt;
      do_reset();
      send_pkts(0, 1, 1, 4);
      for (int t = 0; t < 50 && mon_q.size() < 4; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      n_checks++;
      if (mon_q.size() != 4) $display("FAIL single_count got=%0d exp=4", mon_q.size()); else n_pass++;
      n_checks++;
      if (mon_q.size() == 0) $display("FAIL single_latency got=none exp=%0d", start_cyc[0] + 32'd2);
      else if (mon_q[0].cyc !== start_cyc[0] + 32'd2)
         $display("FAIL single_latency got=%0d exp=%0d", mon_q[0].cyc, start_cyc[0] + 32'd2);
      else n_pass++;
      for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
         n_checks++;
         if ({mon_q[i].g, mon_q[i].c, mon_q[i].d, mon_q[i].cyc} !==
             {1'b0, exp_ctrl(i, 4), exp_data(0, 1, i), mon_q[0].cyc + 32'(i)})
            $display("FAIL single_word%0d got=%b/%h/%h@%0d exp=0/%h/%h@%0d", i, mon_q[i].g,
                     mon_q[i].c, mon_q[i].d, mon_q[i].cyc, exp_ctrl(i, 4), exp_data(0, 1, i),
                     mon_q[0].cyc + 32'(i));
         else n_pass++;
      end
      exp_cnt = CNT_EN ? 32'd1 : 32'd0;
      n_checks++; if (pkt_cnt0 !== exp_cnt) $display("FAIL single_pkt_cnt0 got=%0d exp=%0d", pkt_cnt0, exp_cnt); else n_pass++;
      n_checks++; if (pkt_cnt1 !== 32'd0) $display("FAIL single_pkt_cnt1 got=%0d exp=0", pkt_cnt1); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_after got=%b exp=0", busy); else n_pass++;
   endtask

   task automatic test_tie();
      do_reset();
      fork
         send_pkts(0, 1, 1, 4);
         send_pkts(1, 1, 1, 4);
      join
      for (int t = 0; t < 100 && mon_q.size() < 8; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      n_checks++;
      if (mon_q.size() != 8) $display("FAIL tie_count got=%0d exp=8", mon_q.size()); else n_pass++;
      for (int k = 0; k < 8 && k < mon_q.size(); k++) begin
         n_checks++;
         if ({mon_q[k].g, mon_q[k].c, mon_q[k].d} !==
             {1'(k / 4), exp_ctrl(k % 4, 4), exp_data(k / 4, 1, k % 4)})
            $display("FAIL tie_word%0d got=%b/%h/%h exp=%0d/%h/%h", k, mon_q[k].g, mon_q[k].c,
                     mon_q[k].d, k / 4, exp_ctrl(k % 4, 4), exp_data(k / 4, 1, k % 4));
         else n_pass++;
      end
      n_checks++;
      if (mon_q.size() < 5) $display("FAIL tie_bubble got=missing exp=gap_of_2");
      else if (mon_q[4].cyc !== mon_q[3].cyc + 32'd2)
         $display("FAIL tie_bubble got=%0d exp=%0d", mon_q[4].cyc, mon_q[3].cyc + 32'd2);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int exp_req [4] = '{0, 1, 0, 0};
      int exp_id  [4] = '{1, 1, 2, 3};
      do_reset();
      fork
         send_pkts(0, 1, 3, 4);
         send_pkts(1, 1, 1, 4);
      join
      for (int t = 0; t < 200 && mon_q.size() < 16; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      n_checks++;
      if (mon_q.size() != 16) $display("FAIL b2b_count got=%0d exp=16", mon_q.size()); else n_pass++;
      for (int k = 0; k < 16 && k < mon_q.size(); k++) begin
         n_checks++;
         if ({mon_q[k].g, mon_q[k].c, mon_q[k].d} !==
             {1'(exp_req[k / 4]), exp_ctrl(k % 4, 4), exp_data(exp_req[k / 4], exp_id[k / 4], k % 4)})
            $display("FAIL b2b_word%0d got=%b/%h/%h exp=%0d/%h/%h", k, mon_q[k].g, mon_q[k].c,
                     mon_q[k].d, exp_req[k / 4], exp_ctrl(k % 4, 4),
                     exp_data(exp_req[k / 4], exp_id[k / 4], k % 4));
         else n_pass++;
      end
      n_checks++;
      if (pkt_cnt0 !== (CNT_EN ? 32'd3 : 32'd0))
         $display("FAIL b2b_pkt_cnt0 got=%0d exp=%0d", pkt_cnt0, CNT_EN ? 3 : 0);
      else n_pass++;
      n_checks++;
      if (pkt_cnt1 !== (CNT_EN ? 32'd1 : 32'd0))
         $display("FAIL b2b_pkt_cnt1 got=%0d exp=%0d", pkt_cnt1, CNT_EN ? 1 : 0);
      else n_pass++;
   endtask

   task automatic test_stall();
      do_reset();
      fork
         send_pkts(0, 4, 1, 8);
         begin
            for (int t = 0; t < 100 && mon_q.size() < 3; t++) begin
               @(negedge clk); #1;
            end
            @(posedge clk); #1;
            out_rdy = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               n_checks++;
               if (out_wr !== 1'b0) $display("FAIL stall_out_wr%0d got=%b exp=0", s, out_wr); else n_pass++;
            end
            n_checks++;
            if (in0_rdy !== 1'b0) $display("FAIL stall_in0_rdy got=%b exp=0", in0_rdy); else n_pass++;
            @(posedge clk); #1;
            out_rdy = 1'b1;
         end
      join
      for (int t = 0; t < 100 && mon_q.size() < 8; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      n_checks++;
      if (mon_q.size() != 8) $display("FAIL stall_count got=%0d exp=8", mon_q.size()); else n_pass++;
      for (int k = 0; k < 8 && k < mon_q.size(); k++) begin
         n_checks++;
         if ({mon_q[k].g, mon_q[k].c, mon_q[k].d} !== {1'b0, exp_ctrl(k, 8), exp_data(0, 4, k)})
            $display("FAIL stall_word%0d got=%b/%h/%h exp=0/%h/%h", k, mon_q[k].g, mon_q[k].c,
                     mon_q[k].d, exp_ctrl(k, 8), exp_data(0, 4, k));
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      fork
         send_pkts(0, 5, 1, 6);
         begin
            for (int t = 0; t < 100 && mon_q.size() < 3; t++) begin
               @(negedge clk); #1;
            end
            reset    = 1'b1;
            stop_drv = 1'b1;
            #1;
            n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else n_pass++;
            n_checks++; if (out_wr !== 1'b0) $display("FAIL midrst_out_wr got=%b exp=0", out_wr); else n_pass++;
         end
      join
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      stop_drv = 1'b0;
      mon_q.delete();
      @(negedge clk);
      n_checks++; if (in0_rdy !== 1'b1) $display("FAIL midrst_in0_rdy got=%b exp=1", in0_rdy); else n_pass++;
      n_checks++; if (in1_rdy !== 1'b1) $display("FAIL midrst_in1_rdy got=%b exp=1", in1_rdy); else n_pass++;
      n_checks++; if (out_wr !== 1'b0) $display("FAIL midrst_idle_out_wr got=%b exp=0", out_wr); else n_pass++;
      send_pkts(0, 9, 1, 4);
      for (int t = 0; t < 50 && mon_q.size() < 4; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      n_checks++;
      if (mon_q.size() != 4) $display("FAIL midrst_count got=%0d exp=4", mon_q.size()); else n_pass++;
      for (int k = 0; k < 4 && k < mon_q.size(); k++) begin
         n_checks++;
         if ({mon_q[k].g, mon_q[k].c, mon_q[k].d} !== {1'b0, exp_ctrl(k, 4), exp_data(0, 9, k)})
            $display("FAIL midrst_word%0d got=%b/%h/%h exp=0/%h/%h", k, mon_q[k].g, mon_q[k].c,
                     mon_q[k].d, exp_ctrl(k, 4), exp_data(0, 9, k));
         else n_pass++;
      end
      n_checks++;
      if (pkt_cnt0 !== (CNT_EN ? 32'd1 : 32'd0))
         $display("FAIL midrst_pkt_cnt0 got=%0d exp=%0d", pkt_cnt0, CNT_EN ? 1 : 0);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_tie();
      test_back_to_back();
      test_stall();
      test_reset_mid_packet();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ids_input_arbiter.md
IDS_INPUT_ARBITER -- requirements
Module: ids_input_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64: data bus width of both input streams and the output stream.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8: ctrl bus width.
REQ-003 Parameter FIFO_DEPTH_BITS, default 2: log2 depth of each per-input fallthrough FIFO.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in0_data / in0_ctrl / in0_wr  in  DATA_WIDTH / CTRL_WIDTH / 1  requester 0 stream; word accepted when in0_wr=1.
REQ-007 in0_rdy  out  1  requester 0 may write next cycle.
REQ-008 in1_data / in1_ctrl / in1_wr  in  DATA_WIDTH / CTRL_WIDTH / 1  requester 1 stream.
REQ-009 in1_rdy  out  1  requester 1 may write next cycle.
REQ-010 out_data / out_ctrl  out  DATA_WIDTH / CTRL_WIDTH  word toward the IDS datapath.
REQ-011 out_wr  out  1  out_data/out_ctrl valid and transferred this cycle.
REQ-012 out_rdy  in  1  downstream may accept a word this cycle.
REQ-013 grant  out  1  index of requester currently owning the output; valid while busy=1.
REQ-014 busy  out  1  a packet is in transfer (state HDR or BODY).
REQ-015 pkt_cnt0 / pkt_cnt1  out  32 / 32  packets fully forwarded per requester.

Function
REQ-016 Each input SHALL feed its own fallthrough FIFO of 2^FIFO_DEPTH_BITS words of {ctrl,data}; inN_rdy SHALL equal NOT nearly_full of that FIFO.
REQ-017 Packet framing: one or more words with ctrl!=0 (module headers), then words with ctrl==0, ending on the first ctrl!=0 word after at least one ctrl==0 word; that word is the packet's last word.
REQ-018 States SHALL be IDLE, HDR, BODY.
REQ-019 IDLE: if exactly one FIFO is non-empty, register grant to it and go to HDR; if both are non-empty, grant the requester other than last_grant; if both are empty, stay in IDLE.
REQ-020 HDR: a transferred word with ctrl==0 moves to BODY; a transferred word with ctrl!=0 stays in HDR.
REQ-021 BODY: a transferred word with ctrl!=0 ends the packet, sets last_grant=grant, and returns to IDLE; ctrl==0 stays in BODY.
REQ-022 out_wr SHALL equal (state!=IDLE) AND out_rdy AND granted FIFO non-empty; the granted FIFO pops exactly when out_wr=1.
REQ-023 out_data/out_ctrl SHALL show the granted FIFO head combinationally; the value is don't-care when out_wr=0.
REQ-024 Latency: a word written at cycle N into an empty FIFO with the arbiter in IDLE appears with out_wr=1 at cycle N+2 at the earliest; between packets there is exactly one IDLE bubble cycle.
REQ-025 A granted packet SHALL never be interleaved with the other requester's words, regardless of empty cycles or out_rdy=0 stalls.
REQ-026 A simultaneous FIFO write and read in one cycle SHALL be legal; writing while inN_rdy=0 is a requester error and its result is undefined.

Reset
REQ-027 Reset SHALL asynchronously force state=IDLE, last_grant=1 (requester 0 wins the first tie), grant=0, busy=0, out_wr=0, pkt_cnt0=pkt_cnt1=0, and both FIFOs empty.
REQ-028 Reset mid-packet SHALL discard the partial packet and all FIFO contents; after release, in0_rdy=in1_rdy=1.

Configuration
REQ-029 Macro IDS_ARB_PKT_CNT_EN defined: pkt_cntN SHALL increment by 1 on each last-word transfer of requester N and wrap from 2^32-1 to 0.
REQ-030 Macro IDS_ARB_PKT_CNT_EN undefined: the counters are not built, and pkt_cnt0/pkt_cnt1 are present but tied to 0.

Verification
REQ-031 Requester 0 sends one packet (ctrl FF, 00, 00, 01) with out_rdy=1 -> 4 consecutive out_wr words, identical ctrl/data, grant=0, pkt_cnt0=1.
REQ-032 Both requesters load packets in the same cycle after reset -> requester 0 packet complete first, one bubble cycle, then requester 1, with no interleaving.
REQ-033 Requester 0 sends 3 back-to-back packets while requester 1 holds 1 packet -> output order 0,1,0,0.
REQ-034 out_rdy held low for 5 cycles mid-BODY -> out_wr=0 throughout, in0_rdy=0 once the FIFO is nearly full, no word lost or duplicated after release.
REQ-035 Reset asserted on the 3rd word of a 6-word packet -> busy=0 and out_wr=0 immediately; the next packet is forwarded intact from its first word.
REQ-036 With IDS_ARB_PKT_CNT_EN, pkt_cnt0 preloaded to 32'hFFFFFFFF, one packet -> pkt_cnt0=0; without the macro, pkt_cnt0=0 at all times.
